// File: rtl/nibble_mayor_serial_pkg.sv
// Shared definitions for the bit-serial magnitude comparator: FSM state
// encoding and the default operand width.
package nibble_mayor_serial_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_mayor_serial.sv
// Bit-serial, MSB-first magnitude comparator. Accepts one operand pair over
// valid/ready, walks the bits from the MSB down, and stops at the first bit
// that differs. Returns the larger operand, a B-wins flag, an equal flag and
// the number of bits examined.
module nibble_mayor_serial
    import nibble_mayor_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_mayor,
    output logic               out_sel_b,
    output logic               out_iguales,
    output logic [IDX_W:0]     out_ciclos
);

    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [IDX_W:0]   CNT_ONE = (IDX_W + 1)'(1);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W:0]     cnt;
    logic               bit_differs;
    logic               last_bit;

    // The bit under examination this cycle decides whether the scan ends.
    assign bit_differs = a_q[idx] ^ b_q[idx];
    assign last_bit    = (idx == '0);

    // Ready is a pure decode of the state, so no path exists from out_ready.
    assign in_ready = (state == IDLE);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decode: accept in IDLE, stop scanning at the first
    // differing bit or after bit 0, hand off once the consumer is ready.
    always_comb begin
        // NOTE: default first, so every path assigns state_next and no
        // latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (in_valid)                 state_next = SCAN;
            SCAN:    if (bit_differs || last_bit) state_next = DONE;
            DONE:    if (out_ready)                state_next = IDLE;
            default:                               state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, bit index walk, and registered results.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the operand and index registers are a handful of flops,
            // so clearing them with the rest costs nothing and keeps the
            // post-reset state fully defined.
            a_q         <= '0;
            b_q         <= '0;
            idx         <= '0;
            cnt         <= '0;
            out_valid   <= 1'b0;
            out_mayor   <= '0;
            out_sel_b   <= 1'b0;
            out_iguales <= 1'b0;
            out_ciclos  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= in_a;
                        b_q <= in_b;
                        idx <= IDX_MSB;
                        cnt <= '0;
                    end
                end
                SCAN: begin
                    cnt <= cnt + CNT_ONE;
                    if (bit_differs) begin
                        out_valid   <= 1'b1;
                        out_sel_b   <= b_q[idx];
                        out_mayor   <= b_q[idx] ? b_q : a_q;
                        out_iguales <= 1'b0;
                        out_ciclos  <= cnt + CNT_ONE;
                    end else if (last_bit) begin
                        out_valid   <= 1'b1;
                        out_sel_b   <= 1'b0;
                        out_mayor   <= a_q;
                        out_iguales <= 1'b1;
                        out_ciclos  <= cnt + CNT_ONE;
                    end else begin
                        idx <= idx - IDX_ONE;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule
